// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types and default sizing for the keypad matrix scanner.
// The scan FSM state encoding is visible on a debug port of the top.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN     = 3'd1,
        DEBOUNCE = 3'd2,
        PRESSED  = 3'd3,
        HELD     = 3'd4
    } scan_state_e;

    localparam int DEF_ROWS       = 4;
    localparam int DEF_COLS       = 4;
    localparam int DEF_SCAN_DIV   = 25000;
    localparam int DEF_DEB_TICKS  = 10;
    localparam int DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/keypad_matrix_scanner_fifo.sv
// First-word-fall-through event queue for confirmed key presses.
// Handshake: an entry leaves when pop_i is high while empty_o is low; data_o shows the head.
module kp_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Active-low matrix keypad scanner: tick divider, row synchroniser, scan/debounce FSM,
// per-key toggle flags and a press-event FIFO (valid/ready, pop on key_valid & key_ready).
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter  int ROWS       = DEF_ROWS,
    parameter  int COLS       = DEF_COLS,
    parameter  int SCAN_DIV   = DEF_SCAN_DIV,
    parameter  int DEB_TICKS  = DEF_DEB_TICKS,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int KW         = $clog2(ROWS*COLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS-1:0]      row_in,
    output logic [COLS-1:0]      col_out,
    output logic                 key_valid,
    output logic [KW-1:0]        key_code,
    input  logic                 key_ready,
    output logic                 key_held,
    output logic [ROWS*COLS-1:0] key_toggle,
    output logic                 overflow,
    input  logic                 overflow_clr,
    output logic [2:0]           dbg_state_o,
    output logic                 dbg_tick_o
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [7:0]    DEB_LAST = 8'(DEB_TICKS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    scan_state_e          state_q, state_d;
    logic [DW-1:0]        div_q;
    logic                 tick;
    logic [ROWS-1:0]      row_meta_q, row_sync_q;
    logic [CW-1:0]        col_q;
    logic [RW-1:0]        row_q;
    logic [7:0]           cnt_q;
    logic [ROWS*COLS-1:0] toggle_q;
    logic                 overflow_q;
    logic                 any_low;
    logic [RW-1:0]        low_idx;
    logic                 row_is_low;
    logic [KW-1:0]        code_w;
    logic                 push;
    logic                 fifo_empty, fifo_full;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            div_q      <= tick ? '0 : div_q + 1'b1;
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
        end
    end

    // Lowest low row wins when several rows of one column are closed.
    always_comb begin
        any_low = 1'b0;
        low_idx = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_sync_q[r]) begin
                any_low = 1'b1;
                low_idx = RW'(r);
            end
        end
    end

    assign row_is_low = !row_sync_q[row_q];
    assign code_w     = KW'(int'(col_q) * ROWS + int'(row_q));
    assign push       = tick && (state_q == PRESSED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE:     if (row_sync_q != '1) state_d = SCAN;
                SCAN: begin
                    if (any_low)               state_d = DEBOUNCE;
                    else if (col_q == COL_LAST) state_d = IDLE;
                end
                DEBOUNCE: begin
                    if (!row_is_low)            state_d = IDLE;
                    else if (cnt_q == DEB_LAST) state_d = PRESSED;
                end
                PRESSED:  state_d = HELD;
                HELD:     if (!row_is_low && cnt_q == DEB_LAST) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        col_out  = '1;
        key_held = 1'b0;
        case (state_q)
            IDLE:    col_out = '0;
            HELD: begin
                col_out        = '1;
                col_out[col_q] = 1'b0;
                key_held       = 1'b1;
            end
            default: col_out[col_q] = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            cnt_q    <= '0;
            toggle_q <= '0;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    col_q <= '0;
                    cnt_q <= '0;
                end
                SCAN: begin
                    cnt_q <= '0;
                    if (any_low)                row_q <= low_idx;
                    else if (col_q == COL_LAST) col_q <= '0;
                    else                        col_q <= col_q + 1'b1;
                end
                DEBOUNCE: begin
                    if (row_is_low && cnt_q != DEB_LAST) cnt_q <= cnt_q + 1'b1;
                    else                                 cnt_q <= '0;
                end
                PRESSED: begin
                    cnt_q            <= '0;
                    toggle_q[code_w] <= ~toggle_q[code_w];
                end
                HELD: begin
                    if (!row_is_low) cnt_q <= cnt_q + 1'b1;
                    else             cnt_q <= '0;
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    // A newly dropped press takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                overflow_q <= 1'b0;
        else if (push && fifo_full && !key_ready)  overflow_q <= 1'b1;
        else if (overflow_clr)                     overflow_q <= 1'b0;
    end

    kp_event_fifo #(
        .WIDTH (KW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (code_w),
        .pop_i   (key_ready),
        .data_o  (key_code),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign key_valid   = !fifo_empty;
    assign key_toggle  = toggle_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;
    assign dbg_tick_o  = tick;

endmodule
